// File: rtl/f2i32_arbiter_pkg.sv
// Shared types and constants for the f2i32 arbiter and related shared-unit controllers.
package f2i32arbPkg;

  // Controller sequence: accept -> drive converter -> capture result -> hold response.
  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    CAPT,
    RESP
  } f2i32arb_state_t;

  // Register stages inside the f2i32 converter between ce and a valid o.
  localparam int unsigned CONV_LAT = 1;

endpackage

// File: rtl/f2i32.sv
// IEEE-754 single to 32-bit integer converter, one register stage gated by i_ce.
// Magnitude rounds half up. o_ovf is combinational from i_data/i_op. On overflow the
// magnitude saturates (0x7FFFFFFF signed, 0xFFFFFFFF unsigned) and the stored negate flag
// is sign ^ overflow. The output negation samples i_op combinationally, so the caller must
// hold i_op until the result is taken. Internal registers are intentionally not reset.
module f2i32 (
  input  logic        i_clk,
  input  logic        i_ce,
  input  logic        i_op,
  input  logic [31:0] i_data,
  output logic [31:0] o_data,
  output logic        o_ovf
);

  logic        w_sign;
  logic [7:0]  w_exp;
  logic [63:0] w_sig;
  logic [63:0] w_mag;
  logic        w_big;
  logic [31:0] w_sat;
  logic [31:0] r_mag;
  logic        r_neg;

  assign w_sign = i_data[31];
  assign w_exp  = i_data[30:23];
  assign w_sig  = {40'd0, 1'b1, i_data[22:0]};

  // Value = sig * 2^(exp-150); below 0.5 rounds to zero, huge exponents always overflow.
  always_comb begin
    w_mag = '0;
    w_big = 1'b0;
    if (w_exp >= 8'd190) begin
      w_big = 1'b1;
    end else if (w_exp >= 8'd150) begin
      w_mag = w_sig << (w_exp - 8'd150);
    end else if (w_exp >= 8'd126) begin
      w_mag = (w_sig + (64'd1 << (8'd149 - w_exp))) >> (8'd150 - w_exp);
    end
  end

  assign o_ovf = w_big | (i_op ? (w_mag > 64'h7FFF_FFFF) : (w_mag > 64'hFFFF_FFFF));
  assign w_sat = o_ovf ? (i_op ? 32'h7FFF_FFFF : 32'hFFFF_FFFF) : w_mag[31:0];

  // Result stage, loaded only when enabled.
  always_ff @(posedge i_clk) begin
    if (i_ce) begin
      r_mag <= w_sat;
      r_neg <= w_sign ^ o_ovf;
    end
  end

  assign o_data = (i_op & r_neg) ? (~r_mag + 32'd1) : r_mag;

endmodule

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: searches last+1, last+2, ... modulo NREQ for the first set request.
module rr_arbiter #(
  parameter int NREQ = 4,
  parameter int TAGW = 3
) (
  input  logic [NREQ-1:0] i_req,
  input  logic [TAGW-1:0] i_last,
  output logic [NREQ-1:0] o_gnt,
  output logic [TAGW-1:0] o_idx,
  output logic            o_any
);

  int w_c;

  // Priority scan starting one past the previous winner.
  always_comb begin
    o_gnt = '0;
    o_idx = '0;
    o_any = 1'b0;
    w_c   = 0;
    for (int k = 1; k <= NREQ; k++) begin
      w_c = (int'(i_last) + k) % NREQ;
      if (!o_any && i_req[w_c]) begin
        o_any      = 1'b1;
        o_gnt[w_c] = 1'b1;
        o_idx      = TAGW'(w_c);
      end
    end
  end

endmodule

// File: rtl/f2i32_arbiter.sv
// Shares one f2i32 converter among NREQ requesters with round-robin arbitration and a
// tagged response channel. Optional macro F2I32_ARBITER_STATS_EN adds conversion and
// overflow counters (stat_conv, stat_ovf).
module f2i32_arbiter
  import f2i32arbPkg::*;
#(
  parameter int NREQ = 4,
  parameter int TAGW = 3
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NREQ-1:0]    req_valid,
  output logic [NREQ-1:0]    req_ready,
  input  logic [NREQ-1:0]    req_op,
  input  logic [NREQ*32-1:0] req_data,
  output logic               rsp_valid,
  input  logic               rsp_ready,
  output logic [TAGW-1:0]    rsp_tag,
  output logic [31:0]        rsp_data,
  output logic               rsp_overflow
`ifdef F2I32_ARBITER_STATS_EN
  ,
  output logic [31:0]        stat_conv,
  output logic [31:0]        stat_ovf
`endif
);

  f2i32arb_state_t r_state, w_state_d;

  logic [TAGW-1:0] r_last;
  logic [TAGW-1:0] r_tag;
  logic [31:0]     r_hold_data;
  logic            r_hold_op;
  logic            r_ovf;
  logic            r_rsp_valid;
  logic [TAGW-1:0] r_rsp_tag;
  logic [31:0]     r_rsp_data;
  logic            r_rsp_ovf;

  logic [NREQ-1:0] w_gnt;
  logic [TAGW-1:0] w_gnt_idx;
  logic            w_any;
  logic            w_accept;
  logic            w_rsp_hs;
  logic            w_conv_ce;
  logic            w_conv_ovf;
  logic [31:0]     w_conv_data;
  logic [31:0]     w_sel_data;
  logic            w_sel_op;

  rr_arbiter #(
    .NREQ (NREQ),
    .TAGW (TAGW)
  ) u_rr_arbiter (
    .i_req  (req_valid),
    .i_last (r_last),
    .o_gnt  (w_gnt),
    .o_idx  (w_gnt_idx),
    .o_any  (w_any)
  );

  f2i32 u_f2i32 (
    .i_clk  (clk),
    .i_ce   (w_conv_ce),
    .i_op   (r_hold_op),
    .i_data (r_hold_data),
    .o_data (w_conv_data),
    .o_ovf  (w_conv_ovf)
  );

  // Mux the granted requester's operand and mode.
  always_comb begin
    w_sel_data = '0;
    w_sel_op   = 1'b0;
    for (int k = 0; k < NREQ; k++) begin
      if (w_gnt[k]) begin
        w_sel_data = req_data[32*k +: 32];
        w_sel_op   = req_op[k];
      end
    end
  end

  assign w_rsp_hs = r_rsp_valid & rsp_ready;

  // Next-state, converter enable and accept decision.
  always_comb begin
    w_state_d = r_state;
    w_conv_ce = 1'b0;
    w_accept  = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (w_any) begin
          w_accept  = 1'b1;
          w_state_d = ISSUE;
        end
      end
      ISSUE: begin
        w_conv_ce = 1'b1;
        w_state_d = CAPT;
      end
      CAPT: w_state_d = RESP;
      RESP: begin
        if (w_rsp_hs) begin
          w_accept  = w_any;
          w_state_d = w_any ? ISSUE : IDLE;
        end
      end
      default: w_state_d = IDLE;
    endcase
  end

  // No grant is ever visible while reset is held.
  assign req_ready = (w_accept && !rst) ? w_gnt : '0;

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_state_d;
  end

  // Operand capture, overflow staging and response registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_last      <= TAGW'(NREQ - 1);
      r_tag       <= '0;
      r_hold_data <= '0;
      r_hold_op   <= 1'b0;
      r_ovf       <= 1'b0;
      r_rsp_valid <= 1'b0;
      r_rsp_tag   <= '0;
      r_rsp_data  <= '0;
      r_rsp_ovf   <= 1'b0;
    end else begin
      if (w_accept) begin
        r_hold_data <= w_sel_data;
        r_hold_op   <= w_sel_op;
        r_tag       <= w_gnt_idx;
        r_last      <= w_gnt_idx;
      end
      // Overflow is only valid while the operand is presented, so stage it here.
      if (r_state == ISSUE) r_ovf <= w_conv_ovf;
      if (r_state == CAPT) begin
        r_rsp_data  <= w_conv_data;
        r_rsp_ovf   <= r_ovf;
        r_rsp_tag   <= r_tag;
        r_rsp_valid <= 1'b1;
      end else if (w_rsp_hs) begin
        r_rsp_valid <= 1'b0;
      end
    end
  end

  assign rsp_valid    = r_rsp_valid;
  assign rsp_tag      = r_rsp_tag;
  assign rsp_data     = r_rsp_data;
  assign rsp_overflow = r_rsp_ovf;

`ifdef F2I32_ARBITER_STATS_EN
  logic [31:0] r_stat_conv;
  logic [31:0] r_stat_ovf;

  // Count response handshakes and those flagged as overflow; both wrap.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_stat_conv <= '0;
      r_stat_ovf  <= '0;
    end else if (w_rsp_hs) begin
      r_stat_conv <= r_stat_conv + 32'd1;
      if (r_rsp_ovf) r_stat_ovf <= r_stat_ovf + 32'd1;
    end
  end

  assign stat_conv = r_stat_conv;
  assign stat_ovf  = r_stat_ovf;
`endif

endmodule

// File: tb/tb_f2i32_arbiter.sv
// Directed self-checking bench for f2i32_arbiter.
module tb_f2i32_arbiter;
  import f2i32arbPkg::*;

  localparam int NREQ = 4;
  localparam int TAGW = 3;

  logic               clk = 1'b0;
  logic               rst = 1'b0;
  logic [NREQ-1:0]    req_valid = '0;
  logic [NREQ-1:0]    req_ready;
  logic [NREQ-1:0]    req_op = '0;
  logic [NREQ*32-1:0] req_data = '0;
  logic               rsp_valid;
  logic               rsp_ready = 1'b1;
  logic [TAGW-1:0]    rsp_tag;
  logic [31:0]        rsp_data;
  logic               rsp_overflow;
`ifdef F2I32_ARBITER_STATS_EN
  logic [31:0]        stat_conv;
  logic [31:0]        stat_ovf;
`endif

  int n_vec = 0;
  int n_err = 0;

  f2i32_arbiter #(
    .NREQ (NREQ),
    .TAGW (TAGW)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_op       (req_op),
    .req_data     (req_data),
    .rsp_valid    (rsp_valid),
    .rsp_ready    (rsp_ready),
    .rsp_tag      (rsp_tag),
    .rsp_data     (rsp_data),
    .rsp_overflow (rsp_overflow)
`ifdef F2I32_ARBITER_STATS_EN
    ,
    .stat_conv    (stat_conv),
    .stat_ovf     (stat_ovf)
`endif
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present one request from an idle DUT with rsp_ready high, record what comes back.
  task automatic issue_and_wait(input int k, input logic [31:0] d, input logic op,
                                output logic [NREQ-1:0] rdy, output int lat,
                                output logic [TAGW-1:0] tag, output logic [31:0] data,
                                output logic ovf);
    req_data[32*k +: 32] = d;
    req_op[k]            = op;
    req_valid            = '0;
    req_valid[k]         = 1'b1;
    #1;
    rdy = req_ready;
    tick();
    req_valid = '0;
    lat = 1;
    while (!rsp_valid && lat < 20) begin
      tick();
      lat++;
    end
    tag  = rsp_tag;
    data = rsp_data;
    ovf  = rsp_overflow;
    tick();
  endtask

  task automatic apply_reset();
    rst       = 1'b1;
    req_valid = '0;
    tick();
    tick();
    rst = 1'b0;
    tick();
  endtask

  task automatic test_reset();
    rst       = 1'b1;
    req_valid = '1;
    #3;
    n_vec++; if (req_ready !== 4'b0000) begin
      n_err++; $display("FAIL reset_req_ready got %b want 0000", req_ready); end
    n_vec++; if (rsp_valid !== 1'b0) begin
      n_err++; $display("FAIL reset_rsp_valid got %b want 0", rsp_valid); end
    n_vec++; if (rsp_tag !== 3'd0) begin
      n_err++; $display("FAIL reset_rsp_tag got %0d want 0", rsp_tag); end
    n_vec++; if (rsp_data !== 32'd0) begin
      n_err++; $display("FAIL reset_rsp_data got %h want 0", rsp_data); end
    n_vec++; if (rsp_overflow !== 1'b0) begin
      n_err++; $display("FAIL reset_rsp_overflow got %b want 0", rsp_overflow); end
    n_vec++; if (dut.r_state !== IDLE) begin
      n_err++; $display("FAIL reset_state got %0d want IDLE", dut.r_state); end
    tick();
    tick();
    req_valid = '0;
    rst       = 1'b0;
    tick();
  endtask

  task automatic test_single();
    logic [NREQ-1:0] rdy; int lat; logic [TAGW-1:0] tag; logic [31:0] data; logic ovf;
    rsp_ready = 1'b1;
    issue_and_wait(2, 32'h4049_0FDB, 1'b1, rdy, lat, tag, data, ovf);
    n_vec++; if (rdy !== 4'b0100) begin
      n_err++; $display("FAIL single_req_ready got %b want 0100", rdy); end
    n_vec++; if (lat != 3) begin
      n_err++; $display("FAIL single_latency got %0d want 3", lat); end
    n_vec++; if (tag !== 3'd2) begin
      n_err++; $display("FAIL single_tag got %0d want 2", tag); end
    n_vec++; if (data !== 32'd3) begin
      n_err++; $display("FAIL single_data got %h want 00000003", data); end
    n_vec++; if (ovf !== 1'b0) begin
      n_err++; $display("FAIL single_ovf got %b want 0", ovf); end
    n_vec++; if (rsp_valid !== 1'b0) begin
      n_err++; $display("FAIL single_rsp_drop got %b want 0", rsp_valid); end
  endtask

  task automatic test_signed();
    logic [NREQ-1:0] rdy; int lat; logic [TAGW-1:0] tag; logic [31:0] data; logic ovf;
    issue_and_wait(0, 32'hC020_0000, 1'b1, rdy, lat, tag, data, ovf);
    n_vec++; if (data !== 32'hFFFF_FFFD) begin
      n_err++; $display("FAIL signed_neg_data got %h want fffffffd", data); end
    n_vec++; if (tag !== 3'd0 || ovf !== 1'b0) begin
      n_err++; $display("FAIL signed_neg_tag_ovf got %0d/%b want 0/0", tag, ovf); end
    issue_and_wait(0, 32'hC020_0000, 1'b0, rdy, lat, tag, data, ovf);
    n_vec++; if (data !== 32'd3) begin
      n_err++; $display("FAIL unsigned_neg_data got %h want 00000003", data); end
  endtask

  task automatic test_rounding();
    logic [NREQ-1:0] rdy; int lat; logic [TAGW-1:0] tag; logic [31:0] data; logic ovf;
    issue_and_wait(3, 32'h3F00_0000, 1'b0, rdy, lat, tag, data, ovf);
    n_vec++; if (data !== 32'd1) begin
      n_err++; $display("FAIL round_half_data got %h want 00000001", data); end
    issue_and_wait(3, 32'h3EFF_FFFF, 1'b0, rdy, lat, tag, data, ovf);
    n_vec++; if (data !== 32'd0) begin
      n_err++; $display("FAIL round_below_half got %h want 00000000", data); end
    issue_and_wait(1, 32'h4F00_0000, 1'b0, rdy, lat, tag, data, ovf);
    n_vec++; if (data !== 32'h8000_0000 || ovf !== 1'b0) begin
      n_err++; $display("FAIL unsigned_2p31 got %h/%b want 80000000/0", data, ovf); end
  endtask

  task automatic test_overflow();
    logic [NREQ-1:0] rdy; int lat; logic [TAGW-1:0] tag; logic [31:0] data; logic ovf;
    issue_and_wait(1, 32'h4F80_0000, 1'b1, rdy, lat, tag, data, ovf);
    n_vec++; if (ovf !== 1'b1) begin
      n_err++; $display("FAIL overflow_flag got %b want 1", ovf); end
    n_vec++; if (data !== 32'h8000_0001) begin
      n_err++; $display("FAIL overflow_data got %h want 80000001", data); end
    n_vec++; if (tag !== 3'd1) begin
      n_err++; $display("FAIL overflow_tag got %0d want 1", tag); end
  endtask

  task automatic test_fairness();
    int ng = 0;
    int nr = 0;
    int last_cyc = 0;
    apply_reset();
    rsp_ready = 1'b1;
    req_op    = '0;
    req_data  = {32'h4080_0000, 32'h4040_0000, 32'h4000_0000, 32'h3F80_0000};
    req_valid = '1;
    for (int cyc = 0; cyc < 40 && nr < 8; cyc++) begin
      #1;
      if (req_ready != '0) begin
        n_vec++; if (req_ready !== 4'(1 << (ng % 4))) begin
          n_err++; $display("FAIL fair_grant_%0d got %b want %b", ng, req_ready,
                            4'(1 << (ng % 4))); end
        if (ng > 0) begin
          n_vec++; if (cyc - last_cyc != 3) begin
            n_err++; $display("FAIL fair_spacing_%0d got %0d want 3", ng, cyc - last_cyc); end
        end
        last_cyc = cyc;
        ng++;
      end
      if (rsp_valid) begin
        n_vec++; if (rsp_tag !== 3'(nr % 4) || rsp_data !== 32'(nr % 4 + 1)) begin
          n_err++; $display("FAIL fair_rsp_%0d got %0d/%h want %0d/%h", nr, rsp_tag, rsp_data,
                            nr % 4, nr % 4 + 1); end
        nr++;
      end
      tick();
      if (ng >= 8) req_valid = '0;
    end
    req_valid = '0;
    tick();
    n_vec++; if (ng != 8 || nr != 8) begin
      n_err++; $display("FAIL fair_count got %0d/%0d want 8/8", ng, nr); end
  endtask

  task automatic test_backpressure();
    rsp_ready     = 1'b0;
    req_op        = '0;
    req_op[1]     = 1'b1;
    req_data[63:32]  = 32'h4049_0FDB;
    req_data[127:96] = 32'h3F80_0000;
    req_valid     = 4'b0010;
    #1;
    n_vec++; if (req_ready !== 4'b0010) begin
      n_err++; $display("FAIL bp_first_grant got %b want 0010", req_ready); end
    tick();
    req_valid = 4'b1000;
    #1;
    n_vec++; if (req_ready !== 4'b0000) begin
      n_err++; $display("FAIL bp_issue_no_grant got %b want 0000", req_ready); end
    tick();
    tick();
    for (int i = 0; i < 10; i++) begin
      n_vec++; if (rsp_valid !== 1'b1 || rsp_tag !== 3'd1 || rsp_data !== 32'd3) begin
        n_err++; $display("FAIL bp_hold_%0d got %b/%0d/%h want 1/1/00000003", i, rsp_valid,
                          rsp_tag, rsp_data); end
      n_vec++; if (req_ready !== 4'b0000 || dut.w_conv_ce !== 1'b0) begin
        n_err++; $display("FAIL bp_quiet_%0d got %b/%b want 0000/0", i, req_ready,
                          dut.w_conv_ce); end
      tick();
    end
    rsp_ready = 1'b1;
    #1;
    n_vec++; if (req_ready !== 4'b1000) begin
      n_err++; $display("FAIL bp_release_grant got %b want 1000", req_ready); end
    tick();
    req_valid = '0;
    n_vec++; if (rsp_valid !== 1'b0) begin
      n_err++; $display("FAIL bp_release_drop got %b want 0", rsp_valid); end
    tick();
    tick();
    n_vec++; if (rsp_valid !== 1'b1 || rsp_tag !== 3'd3 || rsp_data !== 32'd1) begin
      n_err++; $display("FAIL bp_next_rsp got %b/%0d/%h want 1/3/00000001", rsp_valid,
                        rsp_tag, rsp_data); end
    tick();
  endtask

  task automatic test_reset_mid();
    logic [NREQ-1:0] rdy; int lat; logic [TAGW-1:0] tag; logic [31:0] data; logic ovf;
    int seen = 0;
    rsp_ready        = 1'b1;
    req_op           = '0;
    req_data[95:64]  = 32'h3F80_0000;
    req_valid        = 4'b0100;
    tick();
    req_valid = '0;
    tick();
    #2;
    rst = 1'b1;
    #1;
    n_vec++; if (rsp_valid !== 1'b0 || dut.r_state !== IDLE) begin
      n_err++; $display("FAIL rst_capt got %b/%0d want 0/IDLE", rsp_valid, dut.r_state); end
    tick();
    rst = 1'b0;
    for (int i = 0; i < 6; i++) begin
      if (rsp_valid) seen++;
      tick();
    end
    n_vec++; if (seen != 0) begin
      n_err++; $display("FAIL rst_capt_ghost got %0d want 0", seen); end
    // Reset while a response is being held must clear rsp_valid without a clock edge.
    rsp_ready        = 1'b0;
    req_data[63:32]  = 32'h4000_0000;
    req_valid        = 4'b0010;
    tick();
    req_valid = '0;
    tick();
    tick();
    n_vec++; if (rsp_valid !== 1'b1) begin
      n_err++; $display("FAIL rst_resp_pre got %b want 1", rsp_valid); end
    #2;
    rst = 1'b1;
    #1;
    n_vec++; if (rsp_valid !== 1'b0) begin
      n_err++; $display("FAIL rst_resp_async got %b want 0", rsp_valid); end
    tick();
    rst       = 1'b0;
    rsp_ready = 1'b1;
    tick();
    issue_and_wait(3, 32'h4040_0000, 1'b0, rdy, lat, tag, data, ovf);
    n_vec++; if (rdy !== 4'b1000 || lat != 3 || tag !== 3'd3 || data !== 32'd3) begin
      n_err++; $display("FAIL rst_recover got %b/%0d/%0d/%h want 1000/3/3/00000003", rdy, lat,
                        tag, data); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_signed();
    test_rounding();
    test_overflow();
    test_fairness();
    test_backpressure();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired got timeout want completion");
    $fatal(1, "watchdog");
  end

endmodule
